// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multi-cycle controller.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_RWB    = 4'd7,
    S_IEX    = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b000100;
  localparam logic [5:0] OP_SW   = 6'b000101;
  localparam logic [5:0] OP_BEQ  = 6'b000110;
  localparam logic [5:0] OP_ADDI = 6'b000111;
  // Immediate-logic group is 001xxx: only the bits above the low three are fixed.
  localparam logic [2:0] OP_IMM_HI = 3'b001;

  localparam logic [2:0] ALU_FUNCT = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_LOGIC = 3'b010;
  localparam logic [2:0] ALU_ADD   = 3'b011;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/multicycle_control_outdec.sv
// Moore output decoder: per-state datapath controls, all forced low while rst is high.
module multicycle_control_outdec
  import multicycle_pkg::*;
#(
  parameter int OPW    = 6,
  parameter int ALUOPW = 3
) (
  input  logic              rst,
  input  state_t            state,
  input  logic [OPW-1:0]    opcode,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              pc_src,
  output logic              iord,
  output logic              mem_read,
  output logic              mem_write,
  output logic              ir_write,
  output logic              reg_dst,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [ALUOPW-1:0] alu_op,
  output logic              instr_done,
  output logic              illegal_op
);

  logic is_imm;
  logic is_addi;
  logic is_legal;

  assign is_imm   = (opcode >> 3) == OPW'(OP_IMM_HI);
  assign is_addi  = opcode == OPW'(OP_ADDI);
  assign is_legal = (opcode == OPW'(OP_R))   || (opcode == OPW'(OP_LW)) ||
                    (opcode == OPW'(OP_SW))  || (opcode == OPW'(OP_BEQ)) ||
                    is_addi || is_imm;

  always_comb begin
    pc_en      = 1'b0;
    pc_src     = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = ALUOPW'(ALU_FUNCT);
    instr_done = 1'b0;
    illegal_op = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          alu_op    = ALUOPW'(ALU_ADD);
          ir_write  = mem_ready;
          pc_en     = mem_ready;
        end
        S_DECODE: begin
          alu_src_b  = SRCB_IMM_SH;
          alu_op     = ALUOPW'(ALU_ADD);
          illegal_op = !is_legal;
          instr_done = !is_legal;
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALUOPW'(ALU_ADD);
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          mem_write  = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ready;
        end
        S_REX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_RT;
          alu_op    = ALUOPW'(ALU_FUNCT);
        end
        S_RWB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        S_IEX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = is_addi ? ALUOPW'(ALU_ADD) : ALUOPW'(ALU_LOGIC);
        end
        S_IWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_RT;
          alu_op     = ALUOPW'(ALU_SUB);
          pc_src     = 1'b1;
          pc_en      = zero;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer: state register and next-state logic; outputs via outdec.
//   state  | meaning
//   FETCH  | read instruction at PC, PC+4 -> PC when memory ready
//   DECODE | branch target -> ALUOut, dispatch on opcode (trap illegal)
//   MEMADR | effective address rs+imm
//   MEMRD  | load read, wait for memory
//   MEMWB  | MDR -> rt
//   MEMWR  | store write, wait for memory
//   REX    | R-type ALU op
//   RWB    | ALUOut -> rd
//   IEX    | immediate ALU op
//   IWB    | ALUOut -> rt
//   BRANCH | compare, take ALUOut target when zero
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int OPW           = 6,
  parameter int ALUOPW        = 3,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPW-1:0]    opcode,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              pc_src,
  output logic              iord,
  output logic              mem_read,
  output logic              mem_write,
  output logic              ir_write,
  output logic              reg_dst,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [ALUOPW-1:0] alu_op,
  output logic              instr_done,
  output logic              illegal_op
);

  state_t state;
  state_t state_next;
  logic   ready;
  logic   is_imm;

  assign ready  = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign is_imm = (opcode >> 3) == OPW'(OP_IMM_HI);

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (ready) state_next = S_DECODE;
      S_DECODE: begin
        if ((opcode == OPW'(OP_LW)) || (opcode == OPW'(OP_SW))) state_next = S_MEMADR;
        else if (opcode == OPW'(OP_R))                          state_next = S_REX;
        else if (opcode == OPW'(OP_BEQ))                        state_next = S_BRANCH;
        else if ((opcode == OPW'(OP_ADDI)) || is_imm)           state_next = S_IEX;
        else                                                    state_next = S_FETCH;
      end
      S_MEMADR: state_next = (opcode == OPW'(OP_LW)) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (ready) state_next = S_MEMWB;
      S_MEMWB:  state_next = S_FETCH;
      S_MEMWR:  if (ready) state_next = S_FETCH;
      S_REX:    state_next = S_RWB;
      S_RWB:    state_next = S_FETCH;
      S_IEX:    state_next = S_IWB;
      S_IWB:    state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      default:  state_next = S_FETCH;
    endcase
  end

  multicycle_control_outdec #(
    .OPW    (OPW),
    .ALUOPW (ALUOPW)
  ) u_outdec (
    .rst        (rst),
    .state      (state),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (ready),
    .pc_en      (pc_en),
    .pc_src     (pc_src),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .instr_done (instr_done),
    .illegal_op (illegal_op)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: expected per-cycle control words queued at drive time, compared each negedge.
module tb_multicycle_control;

  logic       clk = 1'b1;
  logic       rst1, rst0;
  logic [5:0] opcode;
  logic       zero;
  logic       mr1;
  logic       mr0;
  wire [16:0] o1;
  wire [16:0] o0;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [16:0] exp;
    bit          sel;
    string       tag;
  } item_t;

  item_t sb[$];
  item_t cur;
  logic [16:0] obs;

  // {pc_en,pc_src,iord,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,alu_src_a,alu_src_b,alu_op,instr_done,illegal_op}
  localparam logic [16:0] E_ZERO     = 17'b0;
  localparam logic [16:0] E_FETCH_W  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b011,1'b0,1'b0};
  localparam logic [16:0] E_FETCH_R  = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,3'b011,1'b0,1'b0};
  localparam logic [16:0] E_DECODE   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,3'b011,1'b0,1'b0};
  localparam logic [16:0] E_DEC_ILL  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,3'b011,1'b1,1'b1};
  localparam logic [16:0] E_MEMADR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b011,1'b0,1'b0};
  localparam logic [16:0] E_MEMRD    = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,1'b0,1'b0};
  localparam logic [16:0] E_MEMWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,3'b000,1'b1,1'b0};
  localparam logic [16:0] E_MEMWR_W  = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,1'b0,1'b0};
  localparam logic [16:0] E_MEMWR_R  = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,1'b1,1'b0};
  localparam logic [16:0] E_REX      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b000,1'b0,1'b0};
  localparam logic [16:0] E_RWB      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,3'b000,1'b1,1'b0};
  localparam logic [16:0] E_IEX_ADD  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b011,1'b0,1'b0};
  localparam logic [16:0] E_IEX_LOG  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b010,1'b0,1'b0};
  localparam logic [16:0] E_IWB      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,3'b000,1'b1,1'b0};
  localparam logic [16:0] E_BR_T     = {1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b001,1'b1,1'b0};
  localparam logic [16:0] E_BR_N     = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b001,1'b1,1'b0};

  localparam logic [5:0] R = 6'b000000, LW = 6'b000100, SW = 6'b000101, BEQ = 6'b000110;
  localparam logic [5:0] ADDI = 6'b000111;

  always #5 clk = ~clk;

  multicycle_control #(.OPW(6), .ALUOPW(3), .MEM_HANDSHAKE(1'b1)) dut (
    .clk(clk), .rst(rst1), .opcode(opcode), .zero(zero), .mem_ready(mr1),
    .pc_en(o1[16]), .pc_src(o1[15]), .iord(o1[14]), .mem_read(o1[13]), .mem_write(o1[12]),
    .ir_write(o1[11]), .reg_dst(o1[10]), .mem_to_reg(o1[9]), .reg_write(o1[8]),
    .alu_src_a(o1[7]), .alu_src_b(o1[6:5]), .alu_op(o1[4:2]), .instr_done(o1[1]),
    .illegal_op(o1[0])
  );

  multicycle_control #(.OPW(6), .ALUOPW(3), .MEM_HANDSHAKE(1'b0)) dut_nohs (
    .clk(clk), .rst(rst0), .opcode(opcode), .zero(zero), .mem_ready(mr0),
    .pc_en(o0[16]), .pc_src(o0[15]), .iord(o0[14]), .mem_read(o0[13]), .mem_write(o0[12]),
    .ir_write(o0[11]), .reg_dst(o0[10]), .mem_to_reg(o0[9]), .reg_write(o0[8]),
    .alu_src_a(o0[7]), .alu_src_b(o0[6:5]), .alu_op(o0[4:2]), .instr_done(o0[1]),
    .illegal_op(o0[0])
  );

  task automatic check_word(input logic [16:0] got, input logic [16:0] exp, input string tag);
    checks++;
    if (got !== exp) begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      obs = cur.sel ? o0 : o1;
      check_word(obs, cur.exp, cur.tag);
    end
  end

  task automatic step(input logic mr, input logic [5:0] op, input logic z,
                      input logic [16:0] e, input string tag, input bit sel = 1'b0);
    item_t it;
    mr1    = mr;
    opcode = op;
    zero   = z;
    it.exp = e;
    it.sel = sel;
    it.tag = tag;
    sb.push_back(it);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst1 = 1'b1;
    rst0 = 1'b1;
    mr0  = 1'b0;
    step(1'($urandom_range(0, 1)), 6'($urandom), 1'($urandom_range(0, 1)), E_ZERO, "reset_c1");
    step(1'($urandom_range(0, 1)), 6'($urandom), 1'($urandom_range(0, 1)), E_ZERO, "reset_c2");
    #1;
    check_word(o1, E_ZERO, "reset_hold");
    rst1 = 1'b0;

    // R-type; mem_ready low outside FETCH must be ignored
    step(1, R, 0, E_FETCH_R, "r_fetch");
    step(0, R, 1, E_DECODE,  "r_decode");
    step(0, R, 0, E_REX,     "r_rex");
    step(0, R, 0, E_RWB,     "r_wb");

    // LW, 2 fetch waits and 3 read waits
    step(0, LW, 0, E_FETCH_W, "lw_fetch_w1");
    step(0, LW, 0, E_FETCH_W, "lw_fetch_w2");
    step(1, LW, 0, E_FETCH_R, "lw_fetch");
    step(1, LW, 0, E_DECODE,  "lw_decode");
    step(1, LW, 0, E_MEMADR,  "lw_memadr");
    step(0, LW, 0, E_MEMRD,   "lw_memrd_w1");
    step(0, LW, 0, E_MEMRD,   "lw_memrd_w2");
    step(0, LW, 0, E_MEMRD,   "lw_memrd_w3");
    #1;
    check_word(o1, E_MEMRD, "lw_memrd_wait_expired");
    step(1, LW, 0, E_MEMRD,   "lw_memrd");
    step(1, LW, 0, E_MEMWB,   "lw_memwb");

    step(1, BEQ, 0, E_FETCH_R, "beq1_fetch");
    step(1, BEQ, 1, E_DECODE,  "beq1_decode");
    step(1, BEQ, 1, E_BR_T,    "beq1_taken");
    step(1, BEQ, 1, E_FETCH_R, "beq0_fetch");
    step(1, BEQ, 0, E_DECODE,  "beq0_decode");
    step(1, BEQ, 0, E_BR_N,    "beq0_not_taken");

    step(1, 6'b000010, 0, E_FETCH_R, "ill_fetch");
    step(1, 6'b000010, 0, E_DEC_ILL, "ill_decode");
    step(1, 6'b010000, 0, E_FETCH_R, "ill2_fetch");
    step(1, 6'b010000, 0, E_DEC_ILL, "ill2_decode");

    step(1, ADDI, 0, E_FETCH_R, "addi_fetch");
    step(1, ADDI, 0, E_DECODE,  "addi_decode");
    step(1, ADDI, 0, E_IEX_ADD, "addi_iex");
    step(1, ADDI, 0, E_IWB,     "addi_iwb");
    step(1, 6'b001111, 0, E_FETCH_R, "imm_fetch");
    step(1, 6'b001111, 0, E_DECODE,  "imm_decode");
    step(1, 6'b001111, 0, E_IEX_LOG, "imm_iex");
    step(1, 6'b001111, 0, E_IWB,     "imm_iwb");

    step(1, SW, 0, E_FETCH_R, "sw_fetch");
    step(1, SW, 0, E_DECODE,  "sw_decode");
    step(1, SW, 0, E_MEMADR,  "sw_memadr");
    step(0, SW, 0, E_MEMWR_W, "sw_memwr_w");
    step(1, SW, 0, E_MEMWR_R, "sw_memwr");

    // reset during a store wait aborts it
    step(1, SW, 0, E_FETCH_R, "swa_fetch");
    step(1, SW, 0, E_DECODE,  "swa_decode");
    step(1, SW, 0, E_MEMADR,  "swa_memadr");
    step(0, SW, 0, E_MEMWR_W, "swa_memwr_w");
    rst1 = 1'b1;
    step(0, SW, 0, E_ZERO,    "swa_rst");
    rst1 = 1'b0;
    step(0, R, 0, E_FETCH_W, "swa_refetch");

    // no-handshake instance, mem_ready held low
    rst1 = 1'b1;
    step(0, LW, 0, E_ZERO, "nohs_rst", 1'b1);
    rst0 = 1'b0;
    step(0, LW, 0, E_FETCH_R, "nohs_lw_fetch",  1'b1);
    step(0, LW, 0, E_DECODE,  "nohs_lw_decode", 1'b1);
    step(0, LW, 0, E_MEMADR,  "nohs_lw_memadr", 1'b1);
    step(0, LW, 0, E_MEMRD,   "nohs_lw_memrd",  1'b1);
    step(0, LW, 0, E_MEMWB,   "nohs_lw_memwb",  1'b1);
    step(0, SW, 0, E_FETCH_R, "nohs_sw_fetch",  1'b1);
    step(0, SW, 0, E_DECODE,  "nohs_sw_decode", 1'b1);
    step(0, SW, 0, E_MEMADR,  "nohs_sw_memadr", 1'b1);
    step(0, SW, 0, E_MEMWR_R, "nohs_sw_memwr",  1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle successor to the single-cycle opcode decoder. A Moore FSM sequences fetch, decode, execute, memory and writeback over several clocks, and drives datapath enables and muxes cycle by cycle. Adds over the previous generation: parametrised ALUOp/opcode widths, memory wait-state handshake, branch-conditional PC enable, an illegal-opcode trap and an instruction-done strobe. Sits between the instruction register and the shared-memory multi-cycle datapath.

Parameters:
OPW, 6, opcode width; opcode constants are zero-extended to OPW.
ALUOPW, 3, alu_op width (must be at least 3).
MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = mem_ready ignored and treated as 1.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  synchronous, active-high reset.
opcode  in  OPW  IR[31:26]; stable from the cycle after FETCH completes.
zero  in  1  ALU zero flag.
mem_ready  in  1  memory access completes this cycle.
pc_en  out  1  PC load enable (unconditional OR branch-and-zero).
pc_src  out  1  0 = ALU result, 1 = ALUOut register.
iord  out  1  memory address: 0 = PC, 1 = ALUOut.
mem_read  out  1  memory read request.
mem_write  out  1  memory write request.
ir_write  out  1  load IR (and MDR).
reg_dst  out  1  1 = rd, 0 = rt.
mem_to_reg  out  1  1 = MDR, 0 = ALUOut.
reg_write  out  1  register file write.
alu_src_a  out  1  0 = PC, 1 = rs.
alu_src_b  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
alu_op  out  ALUOPW  000 R-type funct, 001 sub/compare, 010 imm-logic, 011 add.
instr_done  out  1  one-cycle pulse in the last cycle of each instruction.
illegal_op  out  1  one-cycle pulse in DECODE on an undefined opcode.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, RWB, IEX, IWB, BRANCH.
- Opcodes: R=000000, LW=000100, SW=000101, BEQ=000110, ADDI=000111, IMM-logic=001xxx. Every other opcode is illegal.
- Reset: rst=1 forces state to FETCH next edge and forces every output to 0 that cycle. Reset mid-instruction aborts the instruction with no further writes.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=011.
  - Holds while mem_ready=0.
  - On mem_ready=1: ir_write=1, pc_en=1, pc_src=0, next state DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=011 (branch target into ALUOut).
  - Next state by opcode: LW/SW to MEMADR; R to REX; BEQ to BRANCH; ADDI/IMM-logic to IEX.
  - Illegal: illegal_op=1, instr_done=1, next state FETCH, no write.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=011. Next state MEMRD (LW) or MEMWR (SW).
- MEMRD: mem_read=1, iord=1. Holds until mem_ready, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next state FETCH.
- MEMWR: mem_write=1, iord=1. Holds until mem_ready; in the mem_ready cycle instr_done=1 and next state FETCH.
- REX: alu_src_a=1, alu_src_b=00, alu_op=000. Next state RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next state FETCH.
- IEX: alu_src_a=1, alu_src_b=10, alu_op=011 for ADDI, 010 for 001xxx. Next state IWB.
- IWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_src=1, pc_en=zero, instr_done=1. Next state FETCH.
- Outputs not listed for a state are 0. mem_read and mem_write are never asserted together.
- Latency at zero wait states: BEQ 3 cycles, R/ADDI/IMM/SW 4, LW 5, illegal 2. Each wait cycle adds exactly 1.
- mem_ready is sampled only in FETCH, MEMRD and MEMWR; it is ignored in all other states.

Decomposition:
- Package multicycle_pkg holds:
  - state enum (4-bit encoding);
  - opcode constants;
  - ALUOp constants;
  - alu_src_b encodings.
- One sub-module, multicycle_control_outdec: purely combinational state+opcode+zero to outputs decoder. The top level holds only the state register and next-state logic.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> all outputs 0; first cycle after release is FETCH with mem_read=1, alu_src_b=01.
- R-type, mem_ready tied 1, opcode=000000 -> 4 cycles; RWB has reg_write=1, reg_dst=1; instr_done pulses once.
- LW with 2 wait cycles in FETCH and 3 in MEMRD -> 10 cycles total; ir_write and pc_en each high exactly once; MEMWB has mem_to_reg=1.
- BEQ with zero=1, then zero=0 -> pc_en=1 and pc_src=1 in BRANCH only for the first; 3 cycles each.
- opcode=000010 -> illegal_op=1 in DECODE, no reg_write/mem_write, back to FETCH after 2 cycles.
- rst asserted during MEMWR wait -> mem_write drops the cycle rst is high, FETCH follows. Repeat with MEM_HANDSHAKE=0 and mem_ready=0 -> LW still completes in 5 cycles.
